// File: rtl/unified_mem_ctrl_pkg.sv
// Shared types and helpers for the unified code/data memory controller.
// Parameter sanity checks and effective-address arithmetic live here.
package mem_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_DATA_BASE = 128;

  // DEPTH must exactly cover the address space and the data region must start inside it.
  function automatic bit params_ok(input int addr_w, input int depth, input int data_base);
    return (depth == (1 << addr_w)) && (data_base >= 0) && (data_base < depth);
  endfunction

  function automatic logic [31:0] ea_calc(input logic [31:0] addr, input logic [31:0] base,
                                          input int addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (addr + base) & mask;
  endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Boot-load stream, fetch port and data port of the unified memory.
// master = processor/loader side, slave = memory controller side.
interface unified_mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              run;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_err;

  modport master (
    output load_valid, load_data, load_last,
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    input  load_ready, run,
    input  if_rdata, if_valid,
    input  d_rdata, d_valid, d_err
  );

  modport slave (
    input  load_valid, load_data, load_last,
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    output load_ready, run,
    output if_rdata, if_valid,
    output d_rdata, d_valid, d_err
  );

endinterface

// File: rtl/unified_mem_ctrl_dp_ram_core.sv
// Single-write, multi-read synchronous RAM with write-first forwarding on every read port.
// Read registers hold their value on cycles without a read enable.
module dp_ram_core #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int NUM_RD = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [NUM_RD-1:0]              re,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array has no reset so it maps onto block RAM and survives a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg <= '0;
        end else if (re[gi]) begin
          rdata_reg <= (we && (waddr == raddr[gi])) ? wdata : mem[raddr[gi]];
        end
      end

      assign rdata[gi] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified code/data memory: boot-load FSM, fetch port, data port with base offset
// and code-region write protection, all served from one array in the same cycle.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DATA_BASE = DEF_DATA_BASE,
  parameter int LOAD_EN   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  unified_mem_ctrl_if.slave  bus
);

  localparam bit              PARAMS_OK = params_ok(ADDR_W, DEPTH, DATA_BASE);
  localparam state_t          ST_INIT   = (LOAD_EN != 0) ? ST_LOAD : ST_RUN;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   BASE_EXT = (ADDR_W + 1)'(DATA_BASE);

  generate
    if (!PARAMS_OK) begin : g_param_err
      $error("unified_mem_ctrl: DEPTH must equal 2**ADDR_W and DATA_BASE must be < DEPTH");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              if_valid_reg, if_valid_next;
  logic              d_valid_reg, d_valid_next;
  logic              d_err_reg, d_err_next;

  logic [ADDR_W-1:0] ea;
  logic              d_wr;
  logic              d_prot;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [1:0]              ram_re;
  logic [1:0][ADDR_W-1:0]  ram_raddr;
  logic [1:0][DATA_W-1:0]  ram_rdata;

  assign ea = ADDR_W'(ea_calc(32'(bus.d_addr), 32'(DATA_BASE), ADDR_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      cnt_reg      <= '0;
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      d_err_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      if_valid_reg <= if_valid_next;
      d_valid_reg  <= d_valid_next;
      d_err_reg    <= d_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    if_valid_next = 1'b0;
    d_valid_next  = 1'b0;
    d_err_next    = 1'b0;
    d_wr          = 1'b0;
    d_prot        = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = ea;
    ram_wdata     = bus.d_wdata;
    ram_re        = '0;
    ram_raddr[0]  = bus.if_addr;
    ram_raddr[1]  = ea;

    unique case (state_reg)
      ST_LOAD: begin
        // Fetch and data requests are dropped entirely while booting.
        if (bus.load_valid) begin
          ram_we    = 1'b1;
          ram_waddr = cnt_reg;
          ram_wdata = bus.load_data;
          cnt_next  = cnt_reg + 1'b1;
          if (bus.load_last || (cnt_reg == CNT_LAST)) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        d_wr   = bus.d_req & bus.d_we;
        d_prot = d_wr & ({1'b0, ea} < BASE_EXT);
        ram_we = d_wr & ~d_prot;
        // A permitted write also reads back through the forwarding path; a rejected one
        // must leave d_rdata untouched, so its read enable is suppressed.
        ram_re[0]     = bus.if_req;
        ram_re[1]     = bus.d_req & ~d_prot;
        if_valid_next = bus.if_req;
        d_valid_next  = bus.d_req;
        d_err_next    = d_prot;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  dp_ram_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_RD (2)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.load_ready = (state_reg == ST_LOAD);
  assign bus.run        = (state_reg == ST_RUN);
  assign bus.if_rdata   = ram_rdata[0];
  assign bus.if_valid   = if_valid_reg;
  assign bus.d_rdata    = ram_rdata[1];
  assign bus.d_valid    = d_valid_reg;
  assign bus.d_err      = d_err_reg;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl: a shadow memory predicts every fetch/data
// response, expectations are queued at drive time and popped when valid appears.
module tb_unified_mem_ctrl;
  import mem_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 256;
  localparam int DATA_BASE = 128;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } d_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .DATA_BASE (DATA_BASE),
    .LOAD_EN   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] if_q [$];
  d_exp_t     d_q [$];
  logic [7:0] mem_model [DEPTH];
  int         cnt_model;
  bit         run_model;
  logic [7:0] d_last;
  int         checks_cnt = 0;
  int         errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // One call = one clock of stimulus; the model is updated as the DUT should be.
  task automatic drive(input bit lv, input logic [7:0] ld, input bit ll,
                       input bit ifr, input logic [7:0] ifa,
                       input bit dr, input bit dwe, input logic [7:0] da,
                       input logic [7:0] dwd);
    logic [7:0] ea;
    bit         prot;
    @(posedge clk);
    #1;
    check_val("load_ready", bus.load_ready, !run_model);
    check_val("run", bus.run, run_model);
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.load_last  = ll;
    bus.if_req     = ifr;
    bus.if_addr    = ifa;
    bus.d_req      = dr;
    bus.d_we       = dwe;
    bus.d_addr     = da;
    bus.d_wdata    = dwd;
    if (!run_model) begin
      if (lv) begin
        mem_model[cnt_model] = ld;
        if (ll || cnt_model == DEPTH - 1) run_model = 1'b1;
        cnt_model++;
      end
    end else begin
      if (dr) begin
        ea   = da + 8'(DATA_BASE);
        prot = dwe && (ea < DATA_BASE);
        if (dwe && !prot) mem_model[ea] = dwd;
        if (!prot) d_last = mem_model[ea];
        d_q.push_back('{data: d_last, err: prot});
      end
      if (ifr) if_q.push_back(mem_model[ifa]);
    end
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic load_byte(input logic [7:0] b, input bit last);
    drive(1'b1, b, last, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic fetch(input logic [7:0] a);
    drive(1'b0, 8'h00, 1'b0, 1'b1, a, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.if_req     = 1'b0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    rst_n = 1'b0;
    #2;
    check_val("rst_if_valid", bus.if_valid, 0);
    check_val("rst_d_valid", bus.d_valid, 0);
    check_val("rst_d_err", bus.d_err, 0);
    check_val("rst_if_rdata", bus.if_rdata, 0);
    check_val("rst_d_rdata", bus.d_rdata, 0);
    check_val("rst_load_ready", bus.load_ready, 1);
    check_val("rst_run", bus.run, 0);
    if_q.delete();
    d_q.delete();
    cnt_model = 0;
    run_model = 1'b0;
    d_last    = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Response monitor: every valid must match the oldest outstanding expectation.
  initial begin
    logic [7:0] ie;
    d_exp_t     de;
    forever begin
      @(negedge clk);
      if (bus.if_valid) begin
        if (if_q.size() == 0) begin
          check_val("if_valid_unexpected", bus.if_valid, 0);
        end else begin
          ie = if_q.pop_front();
          $display("IF   rdata=0x%02h exp=0x%02h", bus.if_rdata, ie);
          check_val("if_rdata", bus.if_rdata, ie);
        end
      end
      if (bus.d_valid) begin
        if (d_q.size() == 0) begin
          check_val("d_valid_unexpected", bus.d_valid, 0);
        end else begin
          de = d_q.pop_front();
          $display("DATA rdata=0x%02h err=%0d exp_rdata=0x%02h exp_err=%0d",
                   bus.d_rdata, bus.d_err, de.data, de.err);
          check_val("d_rdata", bus.d_rdata, de.data);
          check_val("d_err", bus.d_err, de.err);
        end
      end else if (bus.d_err) begin
        check_val("d_err_stray", bus.d_err, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    cnt_model      = 0;
    run_model      = 1'b0;
    d_last         = 8'h00;

    // Full 256-byte load without load_last; requests during LOAD must be ignored.
    do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i ^ 8'h5A), 1'b0, 1'b0, 8'h00, (i == 7), 1'b0, 8'h03, 8'h00);
    end
    idle();
    load_byte(8'h77, 1'b1);
    fetch(8'h00);
    fetch(8'hFF);
    fetch(8'h80);
    idle();
    idle();

    // Short boot image, then fetches across the loaded and retained words.
    do_reset();
    load_byte(8'h10, 1'b0);
    load_byte(8'h11, 1'b0);
    load_byte(8'h12, 1'b1);
    fetch(8'h00);
    fetch(8'h01);
    fetch(8'h02);
    fetch(8'h03);

    // Data write, then fetch and data read of the same word in one cycle.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd5, 8'hA5);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd133, 1'b1, 1'b0, 8'd5, 8'h00);

    // Write wrapping into the code region is rejected.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd200, 8'hFF);
    fetch(8'd72);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd200, 8'h00);

    // Same-cycle write and fetch of one word: fetch sees the new data.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd138, 1'b1, 1'b1, 8'd10, 8'h3C);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'd138, 1'b1, 1'b0, 8'd10, 8'h00);
    idle();
    idle();

    // Reset in the middle of a load, then a 2-byte reload.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      load_byte(8'(i + 8'h20), 1'b0);
    end
    do_reset();
    load_byte(8'hAA, 1'b0);
    load_byte(8'hBB, 1'b1);
    fetch(8'd0);
    fetch(8'd1);
    fetch(8'd2);
    fetch(8'd50);
    fetch(8'd99);
    fetch(8'd100);
    idle();
    idle();
    idle();

    check_val("if_q_left", if_q.size(), 0);
    check_val("d_q_left", d_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
